count_sequence_checker: RTL and testbench
=========================================

Name: count_sequence_checker

Overview:
Receive-side checker for the free-running counter stream that our counter modules emit. It samples a counter value on each valid cycle and locks onto the incrementing sequence. Once locked, it flags and counts every break in the +1 sequence and records the offending values. It sits on the consumer side of any counter-driven data path and is used both as a bench monitor and as synthesizable on-chip self-test.

Parameters:
WIDTH, 8, bit width of the observed counter value.
LOCK_COUNT, 4, number of consecutive in-sequence samples (including the seed) needed to declare lock; legal range 2 to 255.
ERR_W, 16, width of the saturating error and sample statistics counters.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data is sampled on this cycle.
in_data  input  WIDTH  observed counter value.
clr_stats  input  1  synchronous clear of err_count and sample_count.
locked  output  1  checker is in LOCKED state.
err_pulse  output  1  one-cycle pulse per detected sequence break while locked.
err_count  output  ERR_W  saturating count of detected breaks.
sample_count  output  ERR_W  saturating count of in_valid cycles.
exp_value  output  WIDTH  expected value at the most recent error.
got_value  output  WIDTH  received value at the most recent error.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state=SEARCH and expected=0.
  - good_cnt=0 and miss_cnt=0.
  - All outputs are 0.
- All outputs are registered and reflect sample N one clk after the edge on which in_valid was high. Cycles with in_valid=0 change nothing except the effect of clr_stats.
- Match rule: in_data == expected, compared modulo 2^WIDTH. After a match, expected = in_data + 1 truncated to WIDTH, so the all-ones to 0 wrap is a match.
- SEARCH:
  - Any valid sample seeds the checker: expected = in_data + 1, good_cnt = 1, next state LOCKING.
- LOCKING:
  - Match: good_cnt+1 and expected+1.
  - When good_cnt reaches LOCK_COUNT: next state LOCKED, locked=1, good_cnt held.
  - Mismatch: reseed with expected = in_data + 1 and good_cnt = 1. No error is counted.
- LOCKED:
  - Match: expected+1 and miss_cnt=0.
  - Mismatch:
    - err_pulse=1 for exactly one cycle.
    - err_count+1, saturating at all-ones.
    - exp_value = expected and got_value = in_data.
    - Resync with expected = in_data + 1, and miss_cnt+1.
  - A second consecutive mismatch (miss_cnt would become 2) counts and reports as above, then drops lock: locked=0, state LOCKING, good_cnt=1, seeded from that sample.
- sample_count increments on every in_valid cycle in every state and saturates at all-ones.
- clr_stats:
  - Zeroes err_count and sample_count the next cycle. It does not affect state, locked, exp_value or got_value.
  - If asserted on the same cycle as a counted event, the event wins over the clear: err_count=1 and/or sample_count=1.
- in_data is ignored (may be X) when in_valid=0. X on in_data while in_valid=1 is a bench error.

Decomposition:
- Shared package holds:
  - State encoding: SEARCH=2'd0, LOCKING=2'd1, LOCKED=2'd2, with 2'd3 illegal and recovering to SEARCH.
  - Default WIDTH, LOCK_COUNT and ERR_W constants, shared with the counter source.
- One natural sub-module, sat_counter: parameterized ERR_W-bit saturating incrementer with synchronous clear and increment-priority-over-clear. It is instantiated twice, for err_count and sample_count.

Test Plan:
- Valid stream 0,1,2,3,4 every cycle from reset, WIDTH=8, LOCK_COUNT=4 -> locked rises one cycle after sample 3; err_count=0; sample_count=5.
- Locked at 0xFD, then stream 0xFE,0xFF,0x00,0x01 -> no err_pulse; locked stays 1 across the wrap.
- Locked, stream 10,11,20,21 -> single err_pulse one cycle after sample 20; exp_value=12, got_value=20, err_count=1; locked stays 1.
- Locked, stream 10,11,30,50 -> two err_pulses; err_count=2; locked=0 after sample 50; relock after 51,52,53.
- in_valid toggling 1,0,1,0 over 3,4,5,6 after lock -> no errors; gaps are ignored.
- clr_stats coincident with a mismatch while err_count=7 -> err_count=1. Assert reset mid-LOCKED -> all outputs 0 immediately, without waiting for a clk edge; state SEARCH.

Source files
------------

// File: rtl/count_sequence_checker_pkg.sv
// Shared constants and state encoding for the counter-stream sequence checker.
// The default widths are also used by the counter source so both ends agree.
package count_sequence_checker_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefLockCount = 4;
    localparam int unsigned DefErrW      = 16;

    typedef logic [1:0] state_t;

    // 2'd3 is unused; the checker falls back to StSearch if it ever lands there.
    localparam state_t StSearch  = 2'd0;
    localparam state_t StLocking = 2'd1;
    localparam state_t StLocked  = 2'd2;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment on the same
// cycle as a clear leaves the count at one.
module count_sequence_checker_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            if (clr_i) begin
                count_d = W'(1);
            end else if (!(&count_q)) begin
                count_d = count_q + W'(1);
            end
        end else if (clr_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Locks onto an incrementing counter stream, then flags, counts and records
// every break in the +1 sequence. All outputs are registered.
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned LOCK_COUNT = DefLockCount,
    parameter int unsigned ERR_W      = DefErrW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_stats,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] sample_count,
    output logic [WIDTH-1:0] exp_value,
    output logic [WIDTH-1:0] got_value
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [7:0]       good_q, good_d;
    logic [1:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] exp_value_q, exp_value_d;
    logic [WIDTH-1:0] got_value_q, got_value_d;

    logic             match;
    logic             err_event;
    logic [WIDTH-1:0] data_plus1;
    logic [7:0]       good_inc;

    // Natural WIDTH-bit truncation makes the all-ones to zero wrap a match.
    assign data_plus1 = in_data + WIDTH'(1);
    assign match      = (in_data == expected_q);
    assign good_inc   = good_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_d      = good_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        exp_value_d = exp_value_q;
        got_value_d = got_value_q;
        err_event   = 1'b0;

        case (state_q)
            StSearch: begin
                if (in_valid) begin
                    expected_d = data_plus1;
                    good_d     = 8'd1;
                    miss_d     = 2'd0;
                    state_d    = StLocking;
                end
            end

            StLocking: begin
                if (in_valid) begin
                    expected_d = data_plus1;
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == 8'(LOCK_COUNT)) begin
                            state_d  = StLocked;
                            locked_d = 1'b1;
                            miss_d   = 2'd0;
                        end
                    end else begin
                        good_d = 8'd1;
                    end
                end
            end

            StLocked: begin
                if (in_valid) begin
                    expected_d = data_plus1;
                    if (match) begin
                        miss_d = 2'd0;
                    end else begin
                        err_event   = 1'b1;
                        err_pulse_d = 1'b1;
                        exp_value_d = expected_q;
                        got_value_d = in_data;
                        // Two breaks in a row means the stream moved: relock from here.
                        if (miss_q == 2'd1) begin
                            state_d  = StLocking;
                            locked_d = 1'b0;
                            good_d   = 8'd1;
                            miss_d   = 2'd0;
                        end else begin
                            miss_d = miss_q + 2'd1;
                        end
                    end
                end
            end

            default: begin
                state_d    = StSearch;
                expected_d = '0;
                good_d     = 8'd0;
                miss_d     = 2'd0;
                locked_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StSearch;
            expected_q  <= '0;
            good_q      <= 8'd0;
            miss_q      <= 2'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            exp_value_q <= '0;
            got_value_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            exp_value_q <= exp_value_d;
            got_value_q <= got_value_d;
        end
    end

    count_sequence_checker_sat_counter #(
        .W (ERR_W)
    ) u_err_count (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (err_event),
        .clr_i   (clr_stats),
        .count_o (err_count)
    );

    count_sequence_checker_sat_counter #(
        .W (ERR_W)
    ) u_sample_count (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (in_valid),
        .clr_i   (clr_stats),
        .count_o (sample_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign exp_value = exp_value_q;
    assign got_value = got_value_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker with hand-computed expectations.
module tb_count_sequence_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clr_stats;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] sample_count;
    logic [7:0]  exp_value;
    logic [7:0]  got_value;

    int total;
    int bad;

    count_sequence_checker #(
        .WIDTH      (8),
        .LOCK_COUNT (4),
        .ERR_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clr_stats    (clr_stats),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count),
        .exp_value    (exp_value),
        .got_value    (got_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample: drive between edges, check #1 after the capturing edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clr_stats = c;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
        chk({tag, "_smpcnt"}, 32'(sample_count), 32'd0);
        chk({tag, "_exp"}, 32'(exp_value), 32'd0);
        chk({tag, "_got"}, 32'(got_value), 32'd0);
    endtask

    initial begin
        logic [7:0] v8;
        logic [7:0] expv;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clr_stats = 1'b0;
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Lock from reset on 0..4
        step(1'b1, 8'd0, 1'b0); chk("a_s0_locked", 32'(locked), 32'd0);
        step(1'b1, 8'd1, 1'b0); chk("a_s1_locked", 32'(locked), 32'd0);
        step(1'b1, 8'd2, 1'b0); chk("a_s2_locked", 32'(locked), 32'd0);
        step(1'b1, 8'd3, 1'b0); chk("a_s3_locked", 32'(locked), 32'd1);
        step(1'b1, 8'd4, 1'b0);
        chk("a_s4_locked", 32'(locked), 32'd1);
        chk("a_errcnt", 32'(err_count), 32'd0);
        chk("a_smpcnt", 32'(sample_count), 32'd5);
        chk("a_pulse", 32'(err_pulse), 32'd0);

        // Lock at 0xFD, then wrap through zero
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v8 = 8'hFA + 8'(i);
            step(1'b1, v8, 1'b0);
        end
        chk("b_locked_fd", 32'(locked), 32'd1);
        for (int i = 0; i < 4; i++) begin
            v8 = 8'hFE + 8'(i);
            step(1'b1, v8, 1'b0);
            chk("b_wrap_pulse", 32'(err_pulse), 32'd0);
            chk("b_wrap_locked", 32'(locked), 32'd1);
        end
        for (int i = 2; i <= 11; i++) begin
            v8 = 8'(i);
            step(1'b1, v8, 1'b0);
        end

        // Single break: 10,11,20,21
        step(1'b1, 8'd20, 1'b0);
        chk("c_pulse", 32'(err_pulse), 32'd1);
        chk("c_exp", 32'(exp_value), 32'd12);
        chk("c_got", 32'(got_value), 32'd20);
        chk("c_errcnt", 32'(err_count), 32'd1);
        chk("c_locked", 32'(locked), 32'd1);
        step(1'b1, 8'd21, 1'b0);
        chk("c_pulse_off", 32'(err_pulse), 32'd0);
        chk("c_locked2", 32'(locked), 32'd1);

        // Double break drops lock: 22,23,30,50 then relock on 51,52,53
        step(1'b1, 8'd22, 1'b0);
        step(1'b1, 8'd23, 1'b0);
        step(1'b1, 8'd30, 1'b0);
        chk("d_pulse1", 32'(err_pulse), 32'd1);
        chk("d_exp1", 32'(exp_value), 32'd24);
        chk("d_got1", 32'(got_value), 32'd30);
        chk("d_locked1", 32'(locked), 32'd1);
        step(1'b1, 8'd50, 1'b0);
        chk("d_pulse2", 32'(err_pulse), 32'd1);
        chk("d_exp2", 32'(exp_value), 32'd31);
        chk("d_got2", 32'(got_value), 32'd50);
        chk("d_errcnt", 32'(err_count), 32'd3);
        chk("d_unlocked", 32'(locked), 32'd0);
        step(1'b1, 8'd51, 1'b0);
        chk("d_r51_locked", 32'(locked), 32'd0);
        chk("d_r51_pulse", 32'(err_pulse), 32'd0);
        step(1'b1, 8'd52, 1'b0);
        chk("d_r52_locked", 32'(locked), 32'd0);
        step(1'b1, 8'd53, 1'b0);
        chk("d_relocked", 32'(locked), 32'd1);

        // Gaps in in_valid are ignored
        step(1'b1, 8'd54, 1'b0);
        step(1'b0, 8'hxx, 1'b0);
        chk("e_gap_pulse", 32'(err_pulse), 32'd0);
        step(1'b1, 8'd55, 1'b0);
        step(1'b0, 8'hxx, 1'b0);
        chk("e_pulse", 32'(err_pulse), 32'd0);
        chk("e_locked", 32'(locked), 32'd1);
        chk("e_errcnt", 32'(err_count), 32'd3);
        chk("e_smpcnt", 32'(sample_count), 32'd29);
        chk("e_exp_held", 32'(exp_value), 32'd31);
        chk("e_got_held", 32'(got_value), 32'd50);

        // Clear alone on an idle cycle
        step(1'b0, 8'hxx, 1'b1);
        chk("f_clr_errcnt", 32'(err_count), 32'd0);
        chk("f_clr_smpcnt", 32'(sample_count), 32'd0);
        chk("f_clr_locked", 32'(locked), 32'd1);
        chk("f_clr_exp", 32'(exp_value), 32'd31);

        // Seven isolated breaks, each followed by a resync match
        for (int i = 0; i < 7; i++) begin
            v8   = 8'(100 + 10 * i);
            expv = (i == 0) ? 8'd56 : 8'(100 + 10 * i - 8);
            step(1'b1, v8, 1'b0);
            chk("g_pulse", 32'(err_pulse), 32'd1);
            chk("g_exp", 32'(exp_value), 32'(expv));
            v8 = v8 + 8'd1;
            step(1'b1, v8, 1'b0);
        end
        chk("g_errcnt7", 32'(err_count), 32'd7);
        chk("g_smpcnt14", 32'(sample_count), 32'd14);
        chk("g_locked", 32'(locked), 32'd1);

        // Clear coincident with a counted break: the break wins
        step(1'b1, 8'd250, 1'b1);
        chk("h_errcnt", 32'(err_count), 32'd1);
        chk("h_smpcnt", 32'(sample_count), 32'd1);
        chk("h_pulse", 32'(err_pulse), 32'd1);
        chk("h_exp", 32'(exp_value), 32'd162);
        chk("h_got", 32'(got_value), 32'd250);
        chk("h_locked", 32'(locked), 32'd1);

        // Asynchronous reset while locked, between clock edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("i_async");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'd5, 1'b0);
        chk("i_s5_locked", 32'(locked), 32'd0);
        chk("i_s5_smpcnt", 32'(sample_count), 32'd1);
        step(1'b1, 8'd6, 1'b0);
        step(1'b1, 8'd7, 1'b0);
        chk("i_s7_locked", 32'(locked), 32'd0);
        step(1'b1, 8'd8, 1'b0);
        chk("i_s8_locked", 32'(locked), 32'd1);
        chk("i_s8_smpcnt", 32'(sample_count), 32'd4);
        chk("i_s8_errcnt", 32'(err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
